dec_ascii_fmt: RTL and testbench
================================

Name: dec_ascii_fmt

Overview:
Downstream consumer of the binary-to-decimal digit stream (MSD-first BCD nibbles, rts/cts handshake, fixed digits per frame). It formats each frame into printable ASCII for a byte-wide UART transmitter:
- leading-zero suppression;
- optional decimal-point insertion;
- CR/LF terminator.
It sits between the decimal converter and the UART TX, with flow control back-pressuring the converter.

Parameters:
- PAD, 1: 1 = suppressed leading zeros emitted as space (0x20); 0 = suppressed zeros emit no byte.
- TERM, 1: 1 = append CR (0x0D) then LF (0x0A) after each frame; 0 = no terminator.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- dig_cnt  input  4  digits per frame; sampled at the first digit of each frame.
- dp_pos  input  4  digits to the right of the decimal point; 0 = none; sampled with dig_cnt.
- nib_in  input  4  BCD digit from upstream, MSD first.
- nib_rts  input  1  upstream digit valid.
- nib_cts  output  1  block ready for a digit; a digit transfers on a cycle with nib_rts && nib_cts.
- byte_out  output  8  ASCII byte to UART.
- byte_valid  output  1  byte_out valid.
- byte_ready  input  1  UART accepts; a byte transfers on a cycle with byte_valid && byte_ready.
- bad_digit  output  1  one-cycle pulse when an accepted nibble > 9.
- frame_done  output  1  one-cycle pulse when the last byte of a frame transfers.

Behaviour:
Reset values:
- On rst: byte_valid=0, byte_out=0, nib_cts=0, bad_digit=0, frame_done=0.
- Reset state: S_DIG, digit index k=0, lz=1.
- rst mid-frame discards the partial frame and any held byte without completing it. Upstream is reset in the same cycle.

Output register:
- One-entry output holding register.
- While byte_valid && !byte_ready, byte_out is stable.
- The register is free when !byte_valid || byte_ready.

States: S_DIG, S_DP, S_CR, S_LF.

S_DIG:
- nib_cts = register free; nib_cts is combinational from state and byte_valid/byte_ready.
- On transfer, k increments (1-based).
- If k==1, latch D = (dig_cnt==0 ? 1 : dig_cnt) and P = (dp_pos >= D ? 0 : dp_pos).
- Byte emitted:
  - nibble > 9: '?' (0x3F), bad_digit pulses, lz cleared.
  - else if lz && nibble==0 && k < D-P: suppressed; emits 0x20 if PAD, else nothing (register stays empty).
  - else: 0x30+nibble, lz cleared.
- Next state:
  - if P!=0 && k==D-P: go to S_DP;
  - else if k==D: go to S_CR if TERM, else end the frame;
  - else stay in S_DIG.

S_DP:
- nib_cts=0.
- When the register is free, load '.' (0x2E).
- Then go to S_DIG, or to end of frame if k==D.

S_CR / S_LF:
- nib_cts=0.
- Load 0x0D, then 0x0A, each when the register is free.

End of frame:
- k=0, lz=1, state S_DIG.
- frame_done pulses in the cycle the final byte transfers; with PAD=0 and no bytes pending, it pulses on the last digit's accept cycle.

Timing:
- Latency: digit accepted at edge N; byte_valid=1 from edge N onward. With byte_ready held high, throughput is 1 byte/cycle.
- The units digit (k==D-P) is never suppressed. An all-zero frame prints a single '0', or '0.xx' when a decimal point is present.
- dig_cnt/dp_pos changes mid-frame are ignored until the next frame.
- nib_rts without nib_cts: the digit is held by upstream (not dropped).

Decomposition:
- Shared package dec_fmt_pkg holds:
  - ASCII constants: SPACE, ZERO, DOT, QMARK, CR, LF;
  - the state encoding (S_DIG, S_DP, S_CR, S_LF).
- One natural sub-module: byte_hold, the one-entry valid/ready output register. It exposes a load strobe, data, and a free flag.

Test Plan:
- PAD=1, dig_cnt=5, dp_pos=0, digits 0,0,1,2,3, ready=1 -> bytes 20 20 31 32 33 0D 0A; frame_done once.
- dig_cnt=5, dp_pos=2, digits 6,0,8,7,5 -> "608.75\r\n" (36 30 38 2E 37 35 0D 0A).
- dig_cnt=5, dp_pos=2, digits 0,0,0,0,5, PAD=1 -> "  0.05\r\n". Repeat with PAD=0 -> "0.05\r\n".
- Backpressure: byte_ready toggles 1-in-3 during digits 1,2,3 -> byte_out stable while stalled; nib_cts=0 while held; no digit lost or duplicated; output "123\r\n" (PAD=0, dig_cnt=3).
- dig_cnt=4, digits 1,A,0,0 -> "1?00\r\n"; bad_digit pulses exactly once.
- rst asserted after 2 of 5 digits -> byte_valid=0 the next cycle. A following fresh frame 0,0,0,0,7 -> "    7\r\n" (PAD=1) with no stale bytes.

Source files
------------

// File: rtl/dec_ascii_fmt_pkg.sv
// Shared definitions for the decimal-to-ASCII frame formatter: ASCII codes,
// FSM state encoding and the frame-geometry helpers applied at frame start.
package dec_fmt_pkg;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] DOT   = 8'h2E;
    localparam logic [7:0] QMARK = 8'h3F;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    typedef enum logic [1:0] {
        S_DIG = 2'd0,
        S_DP  = 2'd1,
        S_CR  = 2'd2,
        S_LF  = 2'd3
    } state_t;

    // A zero digit count still means a one-digit frame.
    function automatic logic [3:0] eff_digits(input logic [3:0] cnt);
        return (cnt == 4'd0) ? 4'd1 : cnt;
    endfunction

    // A decimal point at or left of the first digit is dropped entirely.
    function automatic logic [3:0] eff_point(input logic [3:0] dp, input logic [3:0] d);
        return (dp >= d) ? 4'd0 : dp;
    endfunction

endpackage

// File: rtl/dec_ascii_fmt_byte_hold.sv
// One-entry valid/ready output register. The owner may only strobe load
// while free is high; the held byte stays stable until the sink takes it.
// A tag bit travels with the byte to mark the final byte of a frame.
module byte_hold (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       last_in,
    input  logic       ready,
    output logic [7:0] dout,
    output logic       valid,
    output logic       last,
    output logic       free
);

    // The slot can be refilled when empty or when its byte leaves this cycle.
    assign free = !valid || ready;

    // Holding register: load has priority, otherwise drain on ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= 8'h00;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
            last  <= last_in;
        end else if (ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            dout  <= dout;
        end else begin
            valid <= valid;
            last  <= last;
            dout  <= dout;
        end
    end

endmodule

// File: rtl/dec_ascii_fmt.sv
// Formats MSD-first BCD digit frames into printable ASCII bytes with
// leading-zero suppression, optional decimal point and CR/LF terminator.
module dec_ascii_fmt
    import dec_fmt_pkg::*;
#(
    parameter bit PAD  = 1'b1,
    parameter bit TERM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig_cnt,
    input  logic [3:0] dp_pos,
    input  logic [3:0] nib_in,
    input  logic       nib_rts,
    output logic       nib_cts,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       bad_digit,
    output logic       frame_done
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] k_r;
    logic [3:0] k_nxt_s;
    logic [3:0] d_r;
    logic [3:0] d_nxt_s;
    logic [3:0] p_r;
    logic [3:0] p_nxt_s;
    logic       lz_r;
    logic       lz_nxt_s;
    logic       bad_r;

    logic [3:0] k_inc_s;
    logic [3:0] d_cur_s;
    logic [3:0] p_cur_s;
    logic [3:0] units_s;
    logic       accept_s;
    logic       load_s;
    logic [7:0] din_s;
    logic       last_s;
    logic       bad_s;
    logic       end_empty_s;

    logic       free_s;
    logic       hold_valid_s;
    logic       hold_last_s;

    byte_hold u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .din     (din_s),
        .last_in (last_s),
        .ready   (byte_ready),
        .dout    (byte_out),
        .valid   (hold_valid_s),
        .last    (hold_last_s),
        .free    (free_s)
    );

    assign byte_valid = hold_valid_s;
    assign bad_digit  = bad_r;

    // The frame ends when its tagged last byte leaves, or at the accept of a
    // final digit that produced no byte at all.
    assign frame_done = !rst && ((hold_valid_s && byte_ready && hold_last_s) || end_empty_s);

    // Next-state, digit classification and output-register load control.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        d_nxt_s     = d_r;
        p_nxt_s     = p_r;
        lz_nxt_s    = lz_r;
        load_s      = 1'b0;
        din_s       = 8'h00;
        last_s      = 1'b0;
        bad_s       = 1'b0;
        end_empty_s = 1'b0;
        nib_cts     = 1'b0;
        accept_s    = 1'b0;
        k_inc_s     = k_r + 4'd1;

        // Frame geometry is captured with the first digit and frozen after.
        if (k_inc_s == 4'd1) begin
            d_cur_s = eff_digits(dig_cnt);
            p_cur_s = eff_point(dp_pos, d_cur_s);
        end else begin
            d_cur_s = d_r;
            p_cur_s = p_r;
        end
        units_s = d_cur_s - p_cur_s;

        case (state_r)
            S_DIG: begin
                nib_cts  = free_s && !rst;
                accept_s = nib_cts && nib_rts;
                if (accept_s) begin
                    k_nxt_s = k_inc_s;
                    d_nxt_s = d_cur_s;
                    p_nxt_s = p_cur_s;
                    if (nib_in > 4'd9) begin
                        load_s   = 1'b1;
                        din_s    = QMARK;
                        bad_s    = 1'b1;
                        lz_nxt_s = 1'b0;
                    end else if (lz_r && (nib_in == 4'd0) && (k_inc_s < units_s)) begin
                        load_s = PAD;
                        din_s  = SPACE;
                    end else begin
                        load_s   = 1'b1;
                        din_s    = ZERO + {4'h0, nib_in};
                        lz_nxt_s = 1'b0;
                    end

                    if ((p_cur_s != 4'd0) && (k_inc_s == units_s)) begin
                        state_nxt_s = S_DP;
                    end else if (k_inc_s == d_cur_s) begin
                        if (TERM) begin
                            state_nxt_s = S_CR;
                        end else begin
                            state_nxt_s = S_DIG;
                            k_nxt_s     = 4'd0;
                            lz_nxt_s    = 1'b1;
                            last_s      = 1'b1;
                            end_empty_s = !load_s;
                        end
                    end else begin
                        state_nxt_s = S_DIG;
                    end
                end else begin
                    state_nxt_s = S_DIG;
                end
            end

            S_DP: begin
                if (free_s) begin
                    load_s = 1'b1;
                    din_s  = DOT;
                    if (k_r == d_r) begin
                        if (TERM) begin
                            state_nxt_s = S_CR;
                        end else begin
                            state_nxt_s = S_DIG;
                            k_nxt_s     = 4'd0;
                            lz_nxt_s    = 1'b1;
                            last_s      = 1'b1;
                        end
                    end else begin
                        state_nxt_s = S_DIG;
                    end
                end else begin
                    state_nxt_s = S_DP;
                end
            end

            S_CR: begin
                if (free_s) begin
                    load_s      = 1'b1;
                    din_s       = CR;
                    state_nxt_s = S_LF;
                end else begin
                    state_nxt_s = S_CR;
                end
            end

            S_LF: begin
                if (free_s) begin
                    load_s      = 1'b1;
                    din_s       = LF;
                    last_s      = 1'b1;
                    state_nxt_s = S_DIG;
                    k_nxt_s     = 4'd0;
                    lz_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = S_LF;
                end
            end

            default: begin
                state_nxt_s = S_DIG;
                k_nxt_s     = 4'd0;
                lz_nxt_s    = 1'b1;
            end
        endcase
    end

    // State, frame counters and the registered bad-digit pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_DIG;
            k_r     <= 4'd0;
            d_r     <= 4'd1;
            p_r     <= 4'd0;
            lz_r    <= 1'b1;
            bad_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
            d_r     <= d_nxt_s;
            p_r     <= p_nxt_s;
            lz_r    <= lz_nxt_s;
            bad_r   <= bad_s;
        end
    end

endmodule

// File: tb/tb_dec_ascii_fmt.sv
// Self-checking bench for dec_ascii_fmt: one padded and one unpadded
// instance, directed frames with literal expectations plus random frames
// checked against a digit-rule reference model.
module tb_dec_ascii_fmt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0][3:0] dig_cnt;
    logic [1:0][3:0] dp_pos;
    logic [1:0][3:0] nib_in;
    logic [1:0]      nib_rts;
    logic [1:0]      nib_cts;
    logic [1:0][7:0] byte_out;
    logic [1:0]      byte_valid;
    logic [1:0]      byte_ready;
    logic [1:0]      bad_digit;
    logic [1:0]      frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] dig_q[$];
    logic [7:0] exp_q[$];

    dec_ascii_fmt #(.PAD(1'b1), .TERM(1'b1)) u_pad (
        .clk(clk), .rst(rst), .dig_cnt(dig_cnt[0]), .dp_pos(dp_pos[0]),
        .nib_in(nib_in[0]), .nib_rts(nib_rts[0]), .nib_cts(nib_cts[0]),
        .byte_out(byte_out[0]), .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]),
        .bad_digit(bad_digit[0]), .frame_done(frame_done[0])
    );

    dec_ascii_fmt #(.PAD(1'b0), .TERM(1'b1)) u_nopad (
        .clk(clk), .rst(rst), .dig_cnt(dig_cnt[1]), .dp_pos(dp_pos[1]),
        .nib_in(nib_in[1]), .nib_rts(nib_rts[1]), .nib_cts(nib_cts[1]),
        .byte_out(byte_out[1]), .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]),
        .bad_digit(bad_digit[1]), .frame_done(frame_done[1])
    );

    // Reference model: expected byte stream of the frame in dig_q.
    task automatic build_expect(input bit pad, input logic [3:0] dc, input logic [3:0] dp);
        int d;
        int p;
        int units;
        int n;
        bit lz;
        exp_q.delete();
        d     = (dc == 4'd0) ? 1 : int'(dc);
        p     = (int'(dp) >= d) ? 0 : int'(dp);
        units = d - p;
        lz    = 1'b1;
        for (int k = 1; k <= d; k++) begin
            n = int'(dig_q[k-1]);
            if (n > 9) begin
                exp_q.push_back(8'h3F);
                lz = 1'b0;
            end else if (lz && n == 0 && k < units) begin
                if (pad) exp_q.push_back(8'h20);
            end else begin
                exp_q.push_back(8'(48 + n));
                lz = 1'b0;
            end
            if (p != 0 && k == units) exp_q.push_back(8'h2E);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Drive dig_q into instance sel and check its byte stream against exp_q.
    task automatic run_frame(input int sel, input logic [3:0] dc, input logic [3:0] dp,
                             input int rmode, input string name);
        int di;
        int bi;
        int cyc;
        int bad_cnt;
        int bad_exp;
        bit held;
        bit started;
        bit xfer;
        bit fd_exp;
        logic [7:0] held_b;
        di = 0; bi = 0; cyc = 0; bad_cnt = 0; bad_exp = 0;
        held = 1'b0; started = 1'b0; held_b = 8'h00;
        foreach (dig_q[i]) if (dig_q[i] > 4'd9) bad_exp++;
        while ((di < dig_q.size() || bi < exp_q.size()) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            case (rmode)
                0:       byte_ready[sel] = 1'b1;
                1:       byte_ready[sel] = (cyc % 3 == 0);
                default: byte_ready[sel] = ($urandom_range(0, 3) != 0);
            endcase
            if (started) begin
                dig_cnt[sel] = 4'($urandom);
                dp_pos[sel]  = 4'($urandom);
            end else begin
                dig_cnt[sel] = dc;
                dp_pos[sel]  = dp;
            end
            if (di < dig_q.size()) begin
                nib_rts[sel] = 1'b1;
                nib_in[sel]  = dig_q[di];
            end else begin
                nib_rts[sel] = 1'b0;
                nib_in[sel]  = 4'($urandom);
            end
            #1;
            if (bad_digit[sel]) bad_cnt++;
            if (held) begin
                n_checks++;
                if (byte_valid[sel] !== 1'b1 || byte_out[sel] !== held_b) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: got valid=%b byte=%h want valid=1 byte=%h",
                             name, byte_valid[sel], byte_out[sel], held_b);
                end
            end
            if (byte_valid[sel] && !byte_ready[sel]) begin
                n_checks++;
                if (nib_cts[sel] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s cts_stall: got %b want 0", name, nib_cts[sel]);
                end
            end
            xfer = byte_valid[sel] && byte_ready[sel];
            if (xfer) begin
                n_checks++;
                if (bi >= exp_q.size()) begin
                    n_fail++;
                    $display("FAIL %s extra_byte: got %h want none", name, byte_out[sel]);
                end else if (byte_out[sel] !== exp_q[bi]) begin
                    n_fail++;
                    $display("FAIL %s byte%0d: got %h want %h", name, bi, byte_out[sel], exp_q[bi]);
                end
                bi++;
            end
            fd_exp = xfer && (bi == exp_q.size());
            n_checks++;
            if (frame_done[sel] !== fd_exp) begin
                n_fail++;
                $display("FAIL %s frame_done cycle %0d: got %b want %b", name, cyc, frame_done[sel], fd_exp);
            end
            if (nib_rts[sel] && nib_cts[sel]) begin
                di++;
                started = 1'b1;
            end
            held   = byte_valid[sel] && !byte_ready[sel];
            held_b = byte_out[sel];
        end
        nib_rts[sel] = 1'b0;
        n_checks++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d bytes want %0d", name, bi, exp_q.size());
        end
        n_checks++;
        if (bad_cnt != bad_exp) begin
            n_fail++;
            $display("FAIL %s bad_digit_count: got %0d want %0d", name, bad_cnt, bad_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (byte_valid[s] !== 1'b0 || byte_out[s] !== 8'h00 || nib_cts[s] !== 1'b0 ||
                bad_digit[s] !== 1'b0 || frame_done[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got v=%b b=%h cts=%b bad=%b fd=%b want all 0",
                         s, byte_valid[s], byte_out[s], nib_cts[s], bad_digit[s], frame_done[s]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_leading_zeros();
        dig_q = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        exp_q = '{8'h20, 8'h20, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
        run_frame(0, 4'd5, 4'd0, 0, "lz_pad");
    endtask

    task automatic test_decimal();
        dig_q = '{4'd6, 4'd0, 4'd8, 4'd7, 4'd5};
        exp_q = '{8'h36, 8'h30, 8'h38, 8'h2E, 8'h37, 8'h35, 8'h0D, 8'h0A};
        run_frame(0, 4'd5, 4'd2, 0, "dp_608");
        dig_q = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
        exp_q = '{8'h20, 8'h20, 8'h30, 8'h2E, 8'h30, 8'h35, 8'h0D, 8'h0A};
        run_frame(0, 4'd5, 4'd2, 0, "dp_005_pad");
        dig_q = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
        exp_q = '{8'h30, 8'h2E, 8'h30, 8'h35, 8'h0D, 8'h0A};
        run_frame(1, 4'd5, 4'd2, 0, "dp_005_nopad");
    endtask

    task automatic test_backpressure();
        dig_q = '{4'd1, 4'd2, 4'd3};
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
        run_frame(1, 4'd3, 4'd0, 1, "backpressure");
    endtask

    task automatic test_bad_digit();
        dig_q = '{4'd1, 4'hA, 4'd0, 4'd0};
        exp_q = '{8'h31, 8'h3F, 8'h30, 8'h30, 8'h0D, 8'h0A};
        run_frame(0, 4'd4, 4'd0, 0, "bad_digit");
    endtask

    task automatic test_boundary();
        dig_q = '{4'd0};
        exp_q = '{8'h30, 8'h0D, 8'h0A};
        run_frame(1, 4'd0, 4'd3, 0, "dig_cnt_zero");
        dig_q = '{4'd0, 4'd0};
        exp_q = '{8'h20, 8'h30, 8'h0D, 8'h0A};
        run_frame(0, 4'd2, 4'd2, 2, "dp_ge_d");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        dig_cnt[0] = 4'd5; dp_pos[0] = 4'd0;
        nib_rts[0] = 1'b1; nib_in[0] = 4'd1; byte_ready[0] = 1'b0;
        @(negedge clk);
        nib_in[0] = 4'd2; byte_ready[0] = 1'b1;
        @(negedge clk);
        nib_rts[0] = 1'b0; byte_ready[0] = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (nib_cts[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset cts_in_rst: got %b want 0", nib_cts[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (byte_valid[0] !== 1'b0 || byte_out[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset flush: got v=%b b=%h want v=0 b=00", byte_valid[0], byte_out[0]);
        end
        n_checks++;
        if (nib_cts[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset cts_after: got %b want 1", nib_cts[0]);
        end
        dig_q = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
        exp_q = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h37, 8'h0D, 8'h0A};
        run_frame(0, 4'd5, 4'd0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [3:0] dc;
        logic [3:0] dp;
        int d;
        int r;
        for (int f = 0; f < 40; f++) begin
            dc = 4'($urandom_range(0, 15));
            dp = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            d  = (dc == 4'd0) ? 1 : int'(dc);
            dig_q.delete();
            for (int i = 0; i < d; i++) begin
                r = $urandom_range(0, 19);
                if (r < 8)       dig_q.push_back(4'd0);
                else if (r == 8) dig_q.push_back(4'($urandom_range(10, 15)));
                else             dig_q.push_back(4'($urandom_range(1, 9)));
            end
            build_expect(f[0] == 1'b0, dc, dp);
            run_frame(f % 2, dc, dp, (f % 3 == 0) ? 0 : 2, "random");
        end
    endtask

    initial begin
        rst        = 1'b1;
        dig_cnt    = '0;
        dp_pos     = '0;
        nib_in     = '0;
        nib_rts    = '0;
        byte_ready = '0;
        test_reset();
        test_leading_zeros();
        test_decimal();
        test_backpressure();
        test_bad_digit();
        test_boundary();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
